// File: rtl/uart_tx_feeder_if.sv
// Handshake bundle between user logic, the TX feeder and the board's UART
// transmit pins (txdata/txclk/txready).
interface uart_tx_feeder_if #(
    parameter int AW = 3
);
    logic          wr_en;
    logic [7:0]    wr_data;
    logic          full;
    logic [AW:0]   count;
    logic          overflow;
    logic          busy;
    logic [7:0]    txdata;
    logic          txclk;
    logic          txready;

    modport slave (
        input  wr_en, wr_data, txready,
        output full, count, overflow, busy, txdata, txclk
    );

    modport master (
        output wr_en, wr_data, txready,
        input  full, count, overflow, busy, txdata, txclk
    );
endinterface

// File: rtl/uart_tx_feeder.sv
// Small circular FIFO that queues user bytes and strobes them one at a time
// onto the UART transmit port bank using a txready down/up handshake.
module uart_tx_feeder #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             hz100,
    input  logic             reset,
    uart_tx_feeder_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, STROBE, WAIT_LOW, WAIT_HIGH} state_t;

    localparam logic [AW:0]   FULL_COUNT = DEPTH[AW:0];
    localparam logic [AW:0]   COUNT_ONE  = 1;
    localparam logic [AW-1:0] PTR_ONE    = 1;

    state_t          state_q, state_d;
    logic [7:0]      mem_q [DEPTH];
    logic [AW-1:0]   wrPtr_q, wrPtr_d;
    logic [AW-1:0]   rdPtr_q, rdPtr_d;
    logic [AW:0]     count_q, count_d;
    logic            overflow_q, overflow_d;
    logic [7:0]      txdata_q, txdata_d;
    logic            txclk_q, txclk_d;
    logic            full;
    logic            push;
    logic            pop;

    // Push is judged on the registered fill level only, so a pop on the same
    // edge never makes room for the incoming byte.
    assign full = (count_q == FULL_COUNT);
    assign push = bus.wr_en && !full;

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (count_q != '0 && bus.txready) begin
                    pop     = 1'b1;
                    state_d = STROBE;
                end
            end
            STROBE:    state_d = WAIT_LOW;
            WAIT_LOW:  if (!bus.txready) state_d = WAIT_HIGH;
            WAIT_HIGH: if (bus.txready)  state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        wrPtr_d    = wrPtr_q;
        rdPtr_d    = rdPtr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        txdata_d   = txdata_q;
        txclk_d    = (state_q == STROBE);
        if (push) wrPtr_d = wrPtr_q + PTR_ONE;
        if (pop) begin
            rdPtr_d  = rdPtr_q + PTR_ONE;
            txdata_d = mem_q[rdPtr_q];
        end
        if (push && !pop)      count_d = count_q + COUNT_ONE;
        else if (pop && !push) count_d = count_q - COUNT_ONE;
        if (bus.wr_en && full) overflow_d = 1'b1;
    end

    always_ff @(posedge hz100) begin
        if (reset) begin
            state_q    <= IDLE;
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            txdata_q   <= 8'h00;
            txclk_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            txdata_q   <= txdata_d;
            txclk_q    <= txclk_d;
        end
    end

    always_ff @(posedge hz100) begin
        if (push) mem_q[wrPtr_q] <= bus.wr_data;
    end

    assign bus.full     = full;
    assign bus.count    = count_q;
    assign bus.overflow = overflow_q;
    assign bus.busy     = (state_q != IDLE);
    assign bus.txdata   = txdata_q;
    assign bus.txclk    = txclk_q;
endmodule

// File: tb/tb_uart_tx_feeder.sv
// Scoreboard bench for uart_tx_feeder: stimulus queues expected TX bytes,
// a monitor checks every txclk strobe against them in order.
module tb_uart_tx_feeder;
    logic hz100;
    logic reset;
    logic modelEn;
    logic modelReady;
    logic tbReady;
    int   checks;
    int   errors;
    logic [7:0] sb[$];

    uart_tx_feeder_if #(.AW(3)) bus();

    uart_tx_feeder #(.DEPTH(8), .AW(3)) dut (
        .hz100 (hz100),
        .reset (reset),
        .bus   (bus.slave)
    );

    assign bus.txready = modelEn ? modelReady : tbReady;

    initial begin
        hz100 = 1'b0;
        forever #5 hz100 = ~hz100;
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "[TB] watchdog");
    end

    // Transmitter model: acknowledges each strobe by dropping txready for one cycle.
    initial begin
        modelReady = 1'b1;
        forever begin
            @(negedge hz100);
            if (modelEn && bus.txclk) begin
                modelReady = 1'b0;
                @(negedge hz100);
                modelReady = 1'b1;
            end
        end
    end

    initial begin
        logic [7:0] exp;
        forever begin
            @(negedge hz100);
            if (bus.txclk === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpectedStrobe: txdata=%02h, none expected", bus.txdata);
                end else begin
                    exp = sb.pop_front();
                    if (bus.txdata !== exp) begin
                        errors++;
                        $display("[TB] FAIL strobeData: got %02h expected %02h", bus.txdata, exp);
                    end
                end
                @(negedge hz100);
                checks++;
                if (bus.txclk !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL strobeWidth: txclk=%b expected 0 one cycle after strobe", bus.txclk);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] data, input bit willSend);
        @(negedge hz100);
        bus.wr_en   = 1'b1;
        bus.wr_data = data;
        if (willSend) sb.push_back(data);
    endtask

    task automatic endStimulus();
        @(negedge hz100);
        bus.wr_en = 1'b0;
    endtask

    task automatic waitIdle(input string name, input int budget);
        int n;
        n = 0;
        @(negedge hz100);
        while ((bus.busy || bus.count != 0 || sb.size() != 0) && n < budget) begin
            @(negedge hz100);
            n++;
        end
        checkOutput({name, "_busy"}, 32'(bus.busy), 32'd0);
        checkOutput({name, "_count"}, 32'(bus.count), 32'd0);
        checkOutput({name, "_sbEmpty"}, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        modelEn     = 1'b1;
        tbReady     = 1'b1;
        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;
        reset       = 1'b1;

        // Reset held for two edges.
        repeat (2) @(negedge hz100);
        reset = 1'b0;
        checkOutput("rstCount", 32'(bus.count), 32'd0);
        checkOutput("rstFull", 32'(bus.full), 32'd0);
        checkOutput("rstTxclk", 32'(bus.txclk), 32'd0);
        checkOutput("rstTxdata", 32'(bus.txdata), 32'h00);
        checkOutput("rstBusy", 32'(bus.busy), 32'd0);
        checkOutput("rstOverflow", 32'(bus.overflow), 32'd0);

        // Single byte with latency checks.
        applyStimulus(8'h41, 1'b1);
        endStimulus();
        checkOutput("lat0Count", 32'(bus.count), 32'd1);
        checkOutput("lat0Busy", 32'(bus.busy), 32'd0);
        @(negedge hz100);
        checkOutput("lat1Busy", 32'(bus.busy), 32'd1);
        checkOutput("lat1Count", 32'(bus.count), 32'd0);
        checkOutput("lat1Txclk", 32'(bus.txclk), 32'd0);
        @(negedge hz100);
        checkOutput("lat2Txclk", 32'(bus.txclk), 32'd1);
        checkOutput("lat2Txdata", 32'(bus.txdata), 32'h41);
        waitIdle("single", 50);

        // Ordering of back-to-back pushes.
        applyStimulus(8'h41, 1'b1);
        applyStimulus(8'h42, 1'b1);
        applyStimulus(8'h43, 1'b1);
        endStimulus();
        waitIdle("order", 100);

        // Fill with transmitter blocked; the ninth byte is dropped.
        modelEn = 1'b0;
        tbReady = 1'b0;
        for (int i = 0; i < 9; i++) applyStimulus(8'(i), i < 8);
        endStimulus();
        checkOutput("fullCount", 32'(bus.count), 32'd8);
        checkOutput("fullFlag", 32'(bus.full), 32'd1);
        checkOutput("fullOverflow", 32'(bus.overflow), 32'd1);
        checkOutput("fullBusy", 32'(bus.busy), 32'd0);
        modelEn = 1'b1;
        waitIdle("drain", 200);
        checkOutput("drainOverflowSticky", 32'(bus.overflow), 32'd1);
        checkOutput("drainFull", 32'(bus.full), 32'd0);

        // Pointer wrap: three rounds of six.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 6; i++) applyStimulus(8'(8'h50 + r * 16 + i), 1'b1);
            endStimulus();
            waitIdle($sformatf("wrap%0d", r), 200);
        end

        // Reset while parked in WAIT_LOW with three bytes queued.
        modelEn = 1'b0;
        tbReady = 1'b1;
        applyStimulus(8'hA0, 1'b1);
        applyStimulus(8'hA1, 1'b0);
        applyStimulus(8'hA2, 1'b0);
        applyStimulus(8'hA3, 1'b0);
        endStimulus();
        checkOutput("midBusy", 32'(bus.busy), 32'd1);
        checkOutput("midCount", 32'(bus.count), 32'd3);
        reset = 1'b1;
        @(negedge hz100);
        reset = 1'b0;
        checkOutput("midRstCount", 32'(bus.count), 32'd0);
        checkOutput("midRstBusy", 32'(bus.busy), 32'd0);
        checkOutput("midRstTxclk", 32'(bus.txclk), 32'd0);
        checkOutput("midRstOverflow", 32'(bus.overflow), 32'd0);
        repeat (10) @(negedge hz100);
        checkOutput("midQuietCount", 32'(bus.count), 32'd0);
        modelEn = 1'b1;
        applyStimulus(8'hB5, 1'b1);
        endStimulus();
        waitIdle("afterRst", 50);

        repeat (3) @(negedge hz100);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
